// File: rtl/stream_sort_defs.sv
// Shared definitions for the serial insertion sorter: FSM encodings and default sizing.
package stream_sort_defs;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam int W_DEF  = 8;
   localparam int N_DEF  = 4;
   localparam int CW_DEF = 3;

endpackage

// File: rtl/stream_sort_insert.sv
// Combinational insert of one word into an ascending array of count valid entries.
// Equal words stay ahead of the new word, so repeated values keep arrival order.
module stream_sort_insert #(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int CW = 3
) (
   input  logic [W-1:0]  mem_in  [N],
   input  logic [CW-1:0] count,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  mem_out [N]
);

   logic [N-1:0] gt;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         gt[i] = (CW'(i) < count) && (mem_in[i] > din);
      end
   end

   // gt is monotonic over the valid region: once an entry exceeds din, all later ones do.
   for (genvar i = 0; i < N; i++) begin : g_slot
      if (i == 0) begin : g_head
         assign mem_out[0] = ((count == '0) || gt[0]) ? din : mem_in[0];
      end else begin : g_tail
         always_comb begin
            if (CW'(i) > count) begin
               mem_out[i] = mem_in[i];
            end else if ((CW'(i) < count) && !gt[i]) begin
               mem_out[i] = mem_in[i];
            end else if (gt[i-1]) begin
               mem_out[i] = mem_in[i-1];
            end else begin
               mem_out[i] = din;
            end
         end
      end
   end

endmodule

// File: rtl/stream_sort.sv
// Serial-in / serial-out sorter: loads up to N words kept sorted on insert, then emits them ascending.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_LOAD | accepting words into the sorted buffer (din_ready once armed)
//   ST_EMIT | streaming buffer out in order; input held off
module stream_sort
   import stream_sort_defs::*;
#(
   parameter int W  = W_DEF,
   parameter int N  = N_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [W-1:0]  din,
   input  logic          din_valid,
   output logic          din_ready,
   input  logic          flush,
   output logic [W-1:0]  dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic          dout_last,
   output logic [CW-1:0] count
);

   state_t        state;
   state_t        state_nxt;
   logic [W-1:0]  mem     [N];
   logic [W-1:0]  mem_ins [N];
   logic [CW-1:0] rd_idx;
   logic [CW-1:0] count_acc;
   logic          started;
   logic          accept;
   logic          xfer;
   logic          last_word;

   assign accept    = din_valid & din_ready;
   assign xfer      = dout_valid & dout_ready;
   assign count_acc = accept ? count + CW'(1) : count;
   assign last_word = (state == ST_EMIT) && (rd_idx == count - CW'(1));

   stream_sort_insert #(.W(W), .N(N), .CW(CW)) u_insert (
      .mem_in  (mem),
      .count   (count),
      .din     (din),
      .mem_out (mem_ins)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD: begin
            if ((accept && (count_acc == CW'(N))) || (flush && (count_acc != '0))) begin
               state_nxt = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (xfer && last_word) begin
               state_nxt = ST_LOAD;
            end
         end
         default: state_nxt = ST_LOAD;
      endcase
   end

   // din_ready stays low for the first edge after reset release.
   always_comb begin
      din_ready  = (state == ST_LOAD) && started;
      dout_valid = (state == ST_EMIT);
      dout_last  = last_word;
      dout       = '0;
      if (state == ST_EMIT) begin
         for (int i = 0; i < N; i++) begin
            if (rd_idx == CW'(i)) begin
               dout = mem[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         started <= 1'b0;
         count   <= '0;
         rd_idx  <= '0;
         for (int i = 0; i < N; i++) begin
            mem[i] <= '0;
         end
      end else begin
         started <= 1'b1;
         if (accept) begin
            mem   <= mem_ins;
            count <= count_acc;
         end
         if (xfer) begin
            if (last_word) begin
               count  <= '0;
               rd_idx <= '0;
            end else begin
               rd_idx <= rd_idx + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_sort.sv
// Randomized and directed bench for stream_sort against a queue-based reference of held words.
module tb_stream_sort;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  din = '0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic          flush = 1'b0;
   logic [W-1:0]  dout;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic          dout_last;
   logic [CW-1:0] count;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] got [$];

   stream_sort #(.W(W), .N(N), .CW(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .flush      (flush),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected completion at %0t", nm, $time);
   endtask

   // Reference: the held set as a plain sorted queue plus an emit position.
   bit           m_started = 1'b0;
   bit           m_emit    = 1'b0;
   int           m_ridx    = 0;
   logic [W-1:0] mq [$];

   always @(posedge clk or negedge reset) begin : model
      bit rdy;
      if (!reset) begin
         m_started = 1'b0;
         m_emit    = 1'b0;
         m_ridx    = 0;
         mq.delete();
      end else begin
         rdy = m_started && !m_emit;
         if (!m_emit) begin
            if (din_valid && rdy) begin
               mq.push_back(din);
               mq.sort();
            end
            if ((mq.size() == N) || (flush && (mq.size() > 0))) begin
               m_emit = 1'b1;
               m_ridx = 0;
            end
         end else if (dout_ready) begin
            if (m_ridx == mq.size() - 1) begin
               mq.delete();
               m_emit = 1'b0;
               m_ridx = 0;
            end else begin
               m_ridx++;
            end
         end
         m_started = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("din_ready", 32'(din_ready), 32'(m_started && !m_emit));
      chk("dout_valid", 32'(dout_valid), 32'(m_emit));
      chk("dout", 32'(dout), m_emit ? 32'(mq[m_ridx]) : 32'd0);
      chk("dout_last", 32'(dout_last), 32'(m_emit && (m_ridx == mq.size() - 1)));
      chk("count", 32'(count), 32'(mq.size()));
      if (reset && dout_valid && dout_ready) got.push_back(dout);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] w, input bit fl);
      int b = 0;
      din       = w;
      din_valid = 1'b1;
      flush     = fl;
      while (!din_ready && b < 50) begin
         tick();
         b++;
      end
      if (!din_ready) timeout_fail("send_wait");
      tick();
      din_valid = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic drain(input int stall, input int maxw);
      int sc = 0;
      int b  = 0;
      int n  = 0;
      bit done = 1'b0;
      while (!done && b < 400) begin
         if (dout_valid) begin
            if (sc < stall) begin
               dout_ready = 1'b0;
               sc++;
            end else begin
               dout_ready = 1'b1;
               sc = 0;
               n++;
               if (dout_last || n == maxw) done = 1'b1;
            end
         end else begin
            dout_ready = 1'b0;
         end
         tick();
         b++;
      end
      dout_ready = 1'b0;
      if (!done) timeout_fail("drain_wait");
   endtask

   task automatic expect_set(input string nm, input logic [W-1:0] e [4], input int n);
      chk({nm, "_len"}, 32'(got.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < got.size()) chk({nm, "_word"}, 32'(got[i]), 32'(e[i]));
      end
      got.delete();
   endtask

   initial begin
      #2 reset = 1'b0;
      repeat (3) tick();
      chk("rst_din_ready", 32'(din_ready), 32'd0);
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      reset = 1'b1;
      #1;
      chk("rel_din_ready_pre", 32'(din_ready), 32'd0);
      tick();
      chk("rel_din_ready_post", 32'(din_ready), 32'd1);

      // full set with a tie
      send(8'h37, 1'b0);
      send(8'h05, 1'b0);
      send(8'hC2, 1'b0);
      send(8'h05, 1'b0);
      chk("full_latency_valid", 32'(dout_valid), 32'd1);
      chk("full_din_ready_low", 32'(din_ready), 32'd0);
      drain(0, 0);
      expect_set("full", '{8'h05, 8'h05, 8'h37, 8'hC2}, 4);

      // flush on an empty buffer does nothing
      pulse_flush();
      chk("flush_empty_count", 32'(count), 32'd0);
      chk("flush_empty_valid", 32'(dout_valid), 32'd0);
      chk("flush_empty_ready", 32'(din_ready), 32'd1);

      // partial set closed by flush together with its last word
      send(8'h80, 1'b0);
      send(8'h10, 1'b0);
      send(8'h40, 1'b1);
      chk("flush_count", 32'(count), 32'd3);
      drain(0, 0);
      expect_set("flush", '{8'h10, 8'h40, 8'h80, 8'h00}, 3);

      // backpressure with the producer pushing during emit
      send(8'hFF, 1'b0);
      send(8'h00, 1'b0);
      send(8'h7F, 1'b0);
      send(8'h01, 1'b0);
      din = 8'hAA;
      din_valid = 1'b1;
      drain(3, 0);
      din_valid = 1'b0;
      chk("bp_ready_after_last", 32'(din_ready), 32'd1);
      expect_set("bp", '{8'h00, 8'h01, 8'h7F, 8'hFF}, 4);

      send(8'h09, 1'b0);
      send(8'h08, 1'b0);
      send(8'h07, 1'b0);
      send(8'h06, 1'b0);
      drain(0, 0);
      expect_set("second", '{8'h06, 8'h07, 8'h08, 8'h09}, 4);

      // reset after two of four words
      send(8'h44, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h11, 1'b0);
      drain(0, 2);
      expect_set("pre_reset", '{8'h11, 8'h22, 8'h00, 8'h00}, 2);
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(dout_valid), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_ready", 32'(din_ready), 32'd0);
      chk("mid_rst_dout", 32'(dout), 32'd0);
      repeat (2) tick();
      #3 reset = 1'b1;
      tick();
      send(8'h3C, 1'b0);
      send(8'h3C, 1'b0);
      send(8'h01, 1'b0);
      send(8'hFE, 1'b0);
      drain(1, 0);
      expect_set("post_reset", '{8'h01, 8'h3C, 8'h3C, 8'hFE}, 4);

      for (int s = 0; s < 40; s++) begin
         int  n;
         bit  narrow;
         bit  fl_with;
         n       = $urandom_range(1, N);
         narrow  = $urandom_range(0, 1) == 1;
         fl_with = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 3) == 0) pulse_flush();
         for (int k = 0; k < n; k++) begin
            logic [W-1:0] w;
            w = narrow ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) tick();
            send(w, (k == n - 1) && (n < N) && fl_with);
         end
         if ((n < N) && !fl_with) begin
            repeat ($urandom_range(0, 2)) tick();
            pulse_flush();
         end
         if ($urandom_range(0, 1) == 1) begin
            din = W'($urandom_range(0, 255));
            din_valid = 1'b1;
         end
         drain($urandom_range(0, 2), 0);
         din_valid = 1'b0;
         got.delete();
      end

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
